lpc_tpm_regs: RTL

Data provider that sits directly downstream of lpc_periph on its data-provider interface, in the LPC clock domain.
- Decodes 16-bit LPC addresses into a TPM TIS 1.3 locality-0 register set: ACCESS, STS/burstCount, DATA_FIFO, DID_VID, RID.
- Owns a single byte-wide command/response buffer and the TIS command state machine.
- Exposes a same-clock buffer port plus an execute/done handshake to the firmware-side consumer.

---
 rtl/lpc_tpm_pkg.sv | 46 ++++
 rtl/lpc_tpm_regs_if.sv | 31 +++
 rtl/lpc_tpm_buf.sv | 55 +++++
 rtl/lpc_tpm_regs.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lpc_tpm_pkg.sv
// Shared types and constants for the LPC TPM TIS locality-0 register block.
package lpc_tpm_pkg;

  // TIS command flow
  typedef enum logic [2:0] {
    StIdle,
    StReady,
    StRecv,
    StExec,
    StCompl
  } tis_state_e;

  // Register offsets within a locality window
  localparam logic [11:0] OffAccess = 12'h000;
  localparam logic [11:0] OffSts    = 12'h018;
  localparam logic [11:0] OffBurst0 = 12'h019;
  localparam logic [11:0] OffBurst1 = 12'h01A;
  localparam logic [11:0] OffFifo   = 12'h024;
  localparam logic [11:0] OffDidVid = 12'hF00;
  localparam logic [11:0] OffRid    = 12'hF04;

  // STS bit positions
  localparam int unsigned StsValidBit     = 7;
  localparam int unsigned StsCmdReadyBit  = 6;
  localparam int unsigned StsTpmGoBit     = 5;
  localparam int unsigned StsDataAvailBit = 4;
  localparam int unsigned StsExpectBit    = 3;

  // ACCESS bit positions
  localparam int unsigned AccValidBit      = 7;
  localparam int unsigned AccActiveBit     = 5;
  localparam int unsigned AccRequestUseBit = 1;

  // Byte idx of a little-endian 32-bit word
  function automatic logic [7:0] le_byte(input logic [31:0] word, input logic [1:0] idx);
    logic [7:0] res;
    unique case (idx)
      2'd0:    res = word[7:0];
      2'd1:    res = word[15:8];
      2'd2:    res = word[23:16];
      default: res = word[31:24];
    endcase
    return res;
  endfunction

endpackage

// File: rtl/lpc_tpm_regs_if.sv
// Data-provider bus between lpc_periph (master) and lpc_tpm_regs (slave).
// Member names keep the slave-side direction suffixes.
interface lpc_tpm_regs_if;
  logic [15:0] lpc_addr_i;
  logic [7:0]  lpc_data_i;
  logic [7:0]  lpc_data_o;
  logic        lpc_data_wr_i;
  logic        lpc_wr_done_o;
  logic        lpc_data_req_i;
  logic        lpc_data_rd_o;

  modport slave (
    input  lpc_addr_i,
    input  lpc_data_i,
    input  lpc_data_wr_i,
    input  lpc_data_req_i,
    output lpc_data_o,
    output lpc_wr_done_o,
    output lpc_data_rd_o
  );

  modport master (
    output lpc_addr_i,
    output lpc_data_i,
    output lpc_data_wr_i,
    output lpc_data_req_i,
    input  lpc_data_o,
    input  lpc_wr_done_o,
    input  lpc_data_rd_o
  );
endinterface

// File: rtl/lpc_tpm_buf.sv
// True dual-port DEPTHx8 command/response buffer with registered reads.
// Port h belongs to the host side, port f to firmware; host wins a same-address write.
module lpc_tpm_buf #(
  parameter int unsigned DEPTH = 64,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          nrst_i,
  input  logic [AW-1:0] h_addr_i,
  input  logic          h_we_i,
  input  logic [7:0]    h_wdata_i,
  output logic [7:0]    h_rdata_o,
  input  logic [AW-1:0] f_addr_i,
  input  logic          f_we_i,
  input  logic [7:0]    f_wdata_i,
  output logic [7:0]    f_rdata_o
);

  logic [7:0] mem_q [DEPTH];
  logic [7:0] h_rdata_d, h_rdata_q;
  logic [7:0] f_rdata_d, f_rdata_q;
  logic       f_we_eff;

  // Read-port data and write arbitration
  always_comb begin
    h_rdata_d = mem_q[h_addr_i];
    f_rdata_d = mem_q[f_addr_i];
    f_we_eff  = f_we_i && !(h_we_i && (h_addr_i == f_addr_i));
  end

  // Storage array; contents are not reset
  always_ff @(posedge clk_i) begin
    if (h_we_i) begin
      mem_q[h_addr_i] <= h_wdata_i;
    end
    if (f_we_eff) begin
      mem_q[f_addr_i] <= f_wdata_i;
    end
  end

  // Registered read data
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      h_rdata_q <= '0;
      f_rdata_q <= '0;
    end else begin
      h_rdata_q <= h_rdata_d;
      f_rdata_q <= f_rdata_d;
    end
  end

  assign h_rdata_o = h_rdata_q;
  assign f_rdata_o = f_rdata_q;

endmodule

// File: rtl/lpc_tpm_regs.sv
// TPM TIS 1.3 locality-0 register set behind lpc_periph, with the command buffer and
// TIS command state machine. Optional feature macro: TWPM_TIS_HDR_LEN_EN (track the
// command header length so STS.expect drops once the whole command has arrived).
module lpc_tpm_regs
  import lpc_tpm_pkg::*;
#(
  parameter int unsigned  DEPTH   = 64,
  parameter logic [31:0]  DID_VID = 32'h0001_1D1D,
  parameter logic [7:0]   RID     = 8'h00,
  localparam int unsigned AW      = $clog2(DEPTH),
  localparam int unsigned CW      = AW + 1
) (
  input  logic          clk_i,
  input  logic          nrst_i,
  lpc_tpm_regs_if.slave lpc,
  output logic          exec_o,
  input  logic          fw_done_i,
  input  logic [CW-1:0] fw_rsp_len_i,
  input  logic [AW-1:0] fw_addr_i,
  input  logic [7:0]    fw_wdata_i,
  input  logic          fw_we_i,
  output logic [7:0]    fw_rdata_o
);

  tis_state_e    state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] rsp_len_q, rsp_len_d;
  logic          active_loc_q, active_loc_d;
  logic          armed_q, armed_d;
  logic          wr_done_q, wr_done_d;
  logic          rd_stage_q, rd_stage_d;
  logic          rd_sel_ram_q, rd_sel_ram_d;
  logic [7:0]    rd_val_q, rd_val_d;
  logic          rd_q, rd_d;
  logic [7:0]    rdata_q, rdata_d;
  logic          exec_q, exec_d;
`ifdef TWPM_TIS_HDR_LEN_EN
  logic [31:0]   hdr_len_q, hdr_len_d;
  logic [CW-1:0] hdr_len_eff;
`endif

  logic          loc0;
  logic [11:0]   off;
  logic          acc_wr, acc_rd;
  logic          fifo_open, data_avail, expect_bit, fifo_rd_hit;
  logic [15:0]   burst;
  logic [7:0]    reg_rdata;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_rdata;

  // Address decode, handshake acceptance and derived status bits
  always_comb begin
    loc0       = (lpc.lpc_addr_i[15:12] == 4'h0);
    off        = lpc.lpc_addr_i[11:0];
    // Write wins when both levels are high
    acc_wr     = armed_q && lpc.lpc_data_wr_i;
    acc_rd     = armed_q && lpc.lpc_data_req_i && !lpc.lpc_data_wr_i;
    fifo_open  = (state_q == StReady) || (state_q == StRecv);
    data_avail = (state_q == StCompl) && (rptr_q < rsp_len_q);
    burst      = fifo_open ? (16'(DEPTH) - 16'(count_q)) : 16'h0000;
`ifdef TWPM_TIS_HDR_LEN_EN
    hdr_len_eff = (hdr_len_q > 32'(DEPTH)) ? CW'(DEPTH) : hdr_len_q[CW-1:0];
    expect_bit  = (state_q == StRecv) && ((count_q < CW'(6)) || (count_q < hdr_len_eff));
`else
    expect_bit  = fifo_open && (count_q < CW'(DEPTH));
`endif
    fifo_rd_hit = loc0 && (off == OffFifo) && data_avail;
  end

  // Register read mux; FIFO data comes from the buffer one cycle later
  always_comb begin
    reg_rdata = 8'hFF;
    if (loc0) begin
      case (off)
        OffAccess: begin
          reg_rdata               = 8'h00;
          reg_rdata[AccValidBit]  = 1'b1;
          reg_rdata[AccActiveBit] = active_loc_q;
        end
        OffSts: begin
          reg_rdata                   = 8'h00;
          reg_rdata[StsValidBit]      = 1'b1;
          reg_rdata[StsCmdReadyBit]   = (state_q == StReady);
          reg_rdata[StsDataAvailBit]  = data_avail;
          reg_rdata[StsExpectBit]     = expect_bit;
        end
        OffBurst0:           reg_rdata = burst[7:0];
        OffBurst1:           reg_rdata = burst[15:8];
        OffDidVid:           reg_rdata = le_byte(DID_VID, 2'd0);
        OffDidVid + 12'h001: reg_rdata = le_byte(DID_VID, 2'd1);
        OffDidVid + 12'h002: reg_rdata = le_byte(DID_VID, 2'd2);
        OffDidVid + 12'h003: reg_rdata = le_byte(DID_VID, 2'd3);
        OffRid:              reg_rdata = RID;
        default:             reg_rdata = 8'hFF;
      endcase
    end
  end

  // Command state machine and register side effects
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    rptr_d       = rptr_q;
    rsp_len_d    = rsp_len_q;
    active_loc_d = active_loc_q;
    ram_we       = 1'b0;
`ifdef TWPM_TIS_HDR_LEN_EN
    hdr_len_d    = hdr_len_q;
`endif
    if (acc_wr && loc0) begin
      case (off)
        OffAccess: begin
          if (lpc.lpc_data_i[AccRequestUseBit]) active_loc_d = 1'b1;
          if (lpc.lpc_data_i[AccActiveBit])     active_loc_d = 1'b0;
        end
        OffSts: begin
          if (lpc.lpc_data_i[StsCmdReadyBit]) begin
            if (state_q == StIdle || state_q == StRecv || state_q == StCompl) begin
              state_d = StReady;
              count_d = '0;
              rptr_d  = '0;
`ifdef TWPM_TIS_HDR_LEN_EN
              hdr_len_d = '0;
`endif
            end
          end else if (lpc.lpc_data_i[StsTpmGoBit] && state_q == StRecv) begin
            state_d = StExec;
          end
        end
        OffFifo: begin
          if (fifo_open) begin
            state_d = StRecv;
            // Bytes beyond the buffer are dropped and count saturates
            if (count_q < CW'(DEPTH)) begin
              ram_we  = 1'b1;
              count_d = count_q + CW'(1);
`ifdef TWPM_TIS_HDR_LEN_EN
              // Command bytes 2..5 hold the big-endian total length
              case (count_q)
                CW'(2):  hdr_len_d[31:24] = lpc.lpc_data_i;
                CW'(3):  hdr_len_d[23:16] = lpc.lpc_data_i;
                CW'(4):  hdr_len_d[15:8]  = lpc.lpc_data_i;
                CW'(5):  hdr_len_d[7:0]   = lpc.lpc_data_i;
                default: ;
              endcase
`endif
            end
          end
        end
        default: ;
      endcase
    end
    if (acc_rd && fifo_rd_hit) begin
      rptr_d = rptr_q + CW'(1);
    end
    if (fw_done_i && state_q == StExec) begin
      rsp_len_d = (fw_rsp_len_i > CW'(DEPTH)) ? CW'(DEPTH) : fw_rsp_len_i;
      rptr_d    = '0;
      state_d   = StCompl;
    end
  end

  // Host handshake pipeline: write done after 1 cycle, read data after 2
  always_comb begin
    armed_d = armed_q;
    if (!lpc.lpc_data_wr_i && !lpc.lpc_data_req_i) begin
      armed_d = 1'b1;
    end else if (acc_wr || acc_rd) begin
      armed_d = 1'b0;
    end
    wr_done_d    = acc_wr;
    rd_stage_d   = acc_rd;
    rd_sel_ram_d = acc_rd && fifo_rd_hit;
    rd_val_d     = acc_rd ? reg_rdata : rd_val_q;
    rd_d         = rd_stage_q;
    rdata_d      = rdata_q;
    if (rd_stage_q) begin
      rdata_d = rd_sel_ram_q ? ram_rdata : rd_val_q;
    end
    exec_d   = (state_d == StExec);
    ram_addr = acc_wr ? count_q[AW-1:0] : rptr_q[AW-1:0];
  end

  // State registers
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state_q      <= StIdle;
      count_q      <= '0;
      rptr_q       <= '0;
      rsp_len_q    <= '0;
      active_loc_q <= 1'b0;
      armed_q      <= 1'b0;
      wr_done_q    <= 1'b0;
      rd_stage_q   <= 1'b0;
      rd_sel_ram_q <= 1'b0;
      rd_val_q     <= '0;
      rd_q         <= 1'b0;
      rdata_q      <= '0;
      exec_q       <= 1'b0;
`ifdef TWPM_TIS_HDR_LEN_EN
      hdr_len_q    <= '0;
`endif
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      rptr_q       <= rptr_d;
      rsp_len_q    <= rsp_len_d;
      active_loc_q <= active_loc_d;
      armed_q      <= armed_d;
      wr_done_q    <= wr_done_d;
      rd_stage_q   <= rd_stage_d;
      rd_sel_ram_q <= rd_sel_ram_d;
      rd_val_q     <= rd_val_d;
      rd_q         <= rd_d;
      rdata_q      <= rdata_d;
      exec_q       <= exec_d;
`ifdef TWPM_TIS_HDR_LEN_EN
      hdr_len_q    <= hdr_len_d;
`endif
    end
  end

  // Firmware writes are only honoured while a command is executing
  lpc_tpm_buf #(
    .DEPTH(DEPTH)
  ) u_buf (
    .clk_i     (clk_i),
    .nrst_i    (nrst_i),
    .h_addr_i  (ram_addr),
    .h_we_i    (ram_we),
    .h_wdata_i (lpc.lpc_data_i),
    .h_rdata_o (ram_rdata),
    .f_addr_i  (fw_addr_i),
    .f_we_i    (fw_we_i && (state_q == StExec)),
    .f_wdata_i (fw_wdata_i),
    .f_rdata_o (fw_rdata_o)
  );

  assign lpc.lpc_data_o    = rdata_q;
  assign lpc.lpc_wr_done_o = wr_done_q;
  assign lpc.lpc_data_rd_o = rd_q;
  assign exec_o            = exec_q;

endmodule
